sram_controller: RTL and testbench
==================================

# sram_controller

Multi-cycle controller between the memory stage and the board's 16-bit external SRAM. It accepts 32-bit word read and write requests from the memory stage and splits each one into two 16-bit SRAM half-word accesses, low half first. It holds `ready` low until the request completes, so the pipeline freeze logic stalls every stage while an access is outstanding.

## Interface
Parameters:
- `ADDR_BASE`, default 1024: byte address that maps to SRAM half-word 0.
- `SRAM_ADDR_W`, default 18: SRAM half-word address width.
- `PHASE_CYCLES`, default 2: cycles each half-word access is held. Legal range is ≥1.

Ports:
- `clk`  in  1: system clock. All state changes on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `rd_en`  in  1: read request from the memory stage.
- `wr_en`  in  1: write request from the memory stage.
- `address`  in  32: byte address (ALU result).
- `write_data`  in  32: store data (Rm value).
- `read_data`  out  32: loaded word, held until the next read completes.
- `ready`  out  1: high when no access is pending or one completes this cycle.
- `sram_dq`  inout  16: SRAM data bus.
- `sram_addr`  out  SRAM_ADDR_W: SRAM half-word address.
- `sram_we_n`, `sram_oe_n`, `sram_ce_n`, `sram_ub_n`, `sram_lb_n`  out  1: active-low SRAM strobes.

## Operation
Address and data mapping:
- `phys = address - ADDR_BASE`, 32-bit with wrap.
- Low half-word address is `{phys[SRAM_ADDR_W:2],1'b0}`; high is `{phys[SRAM_ADDR_W:2],1'b1}`.
- `address[1:0]` is ignored.
- Low half carries bits [15:0] and high half carries bits [31:16] (little-endian).

FSM states: IDLE, LOW, HIGH, DONE.
- IDLE: when `rd_en|wr_en`, latch `address`, `write_data` and the op, then go to LOW.
  - Write has priority when both requests are high.
  - Otherwise stay in IDLE.
- LOW: hold for PHASE_CYCLES cycles, then go to HIGH.
- HIGH: hold for PHASE_CYCLES cycles, then go to DONE.
- DONE: one cycle, then go to IDLE unconditionally.

Signalling:
- `ready = (IDLE & ~rd_en & ~wr_en) | DONE`. This is combinational, so it drops in the same cycle a request appears.
- `sram_ce_n` is 0 in LOW and HIGH, otherwise 1.
- `sram_ub_n` and `sram_lb_n` are always 0.
- Write: `sram_we_n=0`, `sram_oe_n=1`. `sram_dq` is driven with the latched half for the whole phase.
- Read: `sram_we_n=1`, `sram_oe_n=0`, `sram_dq` is high-Z. `sram_dq` is sampled into the matching half of `read_data` on the last cycle of each phase.
- `sram_dq` is high-Z in every state except a write in LOW or HIGH.
- Writes never modify `read_data`.

Because requests are latched, changes on `address` or `write_data` after IDLE do not affect the access in flight.

Reset (asynchronous, at any time including mid-access):
- State goes to IDLE.
- `read_data=0`, `sram_addr=0`.
- `sram_we_n=1`, `sram_oe_n=1`, `sram_ce_n=1`.
- `sram_dq` goes high-Z and the phase counter is cleared.
- `ready` follows the IDLE equation.
- A partially written word is left partially written; no rollback.

## Timing
- Request first seen in IDLE at cycle 0.
- LOW occupies cycles 1..P, HIGH occupies P+1..2P, DONE is cycle 2P+1 (P = PHASE_CYCLES).
- `ready` is low in cycles 0..2P and high in 2P+1. With the default P=2, that is a 5-cycle stall with ready at cycle 5.
- `read_data` is valid from the edge ending the last HIGH cycle, i.e. it is already valid in DONE.
- Back-to-back requests: a new request in the cycle after DONE starts in IDLE again. No request is lost, and there is no idle bubble beyond the IDLE detection cycle.
- `sram_addr` changes only at phase boundaries.

## Configuration
`SRAM_RANGE_CHECK_EN`:
- Defined: a request with `address < ADDR_BASE`, or `phys >= 2^(SRAM_ADDR_W+1)`, goes IDLE→DONE directly.
  - No strobes are asserted.
  - A read returns `read_data=32'h0`.
  - `ready` rises at cycle 1.
- Undefined: no check. Out-of-range addresses wrap modulo SRAM size through the bit slice above.

## Test plan
- Reset: assert `rst` mid-cycle with no clock edge. Expect `read_data=0`, `sram_we_n=1`, `sram_oe_n=1`, `sram_ce_n=1`, `sram_dq` Z, and `ready=1` with no request.
- Write then read, P=2:
  - Write `32'hDEADBEEF` at 1024. Expect half-word 0 = BEEF, half-word 1 = DEAD, `ready` low cycles 0–4 and high at cycle 5.
  - Read 1024. Expect `read_data=32'hDEADBEEF` at DONE.
- Adjacency and alignment: write `32'h12345678` at 1028, then read 1024 and 1031. Expect `DEADBEEF` and `12345678` respectively.
- Request priority and latching: assert `rd_en` and `wr_en` together at 1032 with `32'hA5A5_5A5A` and change `address` during LOW. Expect a write to half-words 4 and 5 only.
- Reset mid-access: assert `rst` during HIGH of a read. Expect immediate IDLE, strobes inactive, `read_data=0`; the next read completes normally in 6 cycles.
- Range check: read at 1020.
  - With `SRAM_RANGE_CHECK_EN`: `ready` at cycle 1, `read_data=0`, `sram_ce_n` stays 1.
  - Without it: full 6-cycle access at wrapped half-word `{(2^SRAM_ADDR_W)-2, (2^SRAM_ADDR_W)-1}`.

Source files
------------

// File: rtl/sram_controller.sv
// sram_controller
//
// Multi-cycle bridge between the memory stage and a 16-bit asynchronous
// SRAM. Each 32-bit word request becomes two half-word accesses, low half
// (bits [15:0]) first, then high half (bits [31:16]). Each half is held for
// PHASE_CYCLES cycles.
//
// Handshake: a request is rd_en/wr_en held high while ready is low. ready is
// combinational: it drops in the cycle a request is seen in IDLE and rises
// again in DONE, the single cycle in which the access completes. The
// requester holds rd_en/wr_en until that DONE cycle or drops them after the
// IDLE cycle; address and write_data are latched in IDLE, so later changes do
// not affect the access in flight. Write wins when both enables are high.
//
// Optional feature macro: SRAM_RANGE_CHECK_EN
//   defined   - requests below ADDR_BASE or past the SRAM size skip straight
//               to DONE with no strobes; such a read returns zero.
//   undefined - out-of-range addresses wrap through the address slice.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   rd_en, wr_en        read / write request
//   address, write_data byte address and store data
//   read_data           last loaded word, held until the next read completes
//   ready               no access pending, or one completes this cycle
//   sram_dq             bidirectional SRAM data bus
//   sram_addr           SRAM half-word address
//   sram_*_n            active-low SRAM strobes
//   dbg_state           current FSM state (IDLE=0, LOW=1, HIGH=2, DONE=3)

module sram_controller #(
    parameter logic [31:0] ADDR_BASE    = 32'd1024,
    parameter int          SRAM_ADDR_W  = 18,
    parameter int          PHASE_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rd_en,
    input  logic                   wr_en,
    input  logic [31:0]            address,
    input  logic [31:0]            write_data,
    output logic [31:0]            read_data,
    output logic                   ready,
    inout  wire  [15:0]            sram_dq,
    output logic [SRAM_ADDR_W-1:0] sram_addr,
    output logic                   sram_we_n,
    output logic                   sram_oe_n,
    output logic                   sram_ce_n,
    output logic                   sram_ub_n,
    output logic                   sram_lb_n,
    output logic [1:0]             dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int            CW       = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(PHASE_CYCLES - 1);

    state_t                 state;
    state_t                 state_nx;
    logic [CW-1:0]          cnt;
    logic                   op_wr;
    logic [SRAM_ADDR_W-2:0] hw_base;
    logic [31:0]            wdata;
    logic [31:0]            phys;
    logic                   req;
    logic                   phase_last;
    logic                   active;
    logic                   out_of_range;
    logic                   unused_phys;

    assign phys       = address - ADDR_BASE;
    assign req        = rd_en | wr_en;
    assign phase_last = (cnt == CNT_LAST);
    assign active     = (state == LOW) || (state == HIGH);
    assign dbg_state  = state;

    // Byte offset bits are ignored; bits above the SRAM range only matter to
    // the optional range check.
    assign unused_phys = ^{phys[31:SRAM_ADDR_W+1], phys[1:0]};

`ifdef SRAM_RANGE_CHECK_EN
    assign out_of_range = (address < ADDR_BASE) || (phys[31:SRAM_ADDR_W+1] != '0);
`else
    assign out_of_range = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (req) state_nx = out_of_range ? DONE : LOW;
            LOW:  if (phase_last) state_nx = HIGH;
            HIGH: if (phase_last) state_nx = DONE;
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            op_wr     <= 1'b0;
            hw_base   <= '0;
            wdata     <= '0;
            read_data <= '0;
            sram_addr <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (req) begin
                        op_wr   <= wr_en;
                        hw_base <= phys[SRAM_ADDR_W:2];
                        wdata   <= write_data;
                        cnt     <= '0;
                        if (!out_of_range) begin
                            sram_addr <= {phys[SRAM_ADDR_W:2], 1'b0};
                        end else if (!wr_en) begin
                            read_data <= '0;
                        end
                    end
                end
                LOW: begin
                    if (phase_last) begin
                        cnt       <= '0;
                        sram_addr <= {hw_base, 1'b1};
                        if (!op_wr) read_data[15:0] <= sram_dq;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HIGH: begin
                    if (phase_last) begin
                        cnt <= '0;
                        if (!op_wr) read_data[31:16] <= sram_dq;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Strobes decode straight from state so reset forces them inactive
    // without waiting for a clock edge.
    assign ready     = ((state == IDLE) && !rd_en && !wr_en) || (state == DONE);
    assign sram_ce_n = ~active;
    assign sram_we_n = ~(active & op_wr);
    assign sram_oe_n = ~(active & ~op_wr);
    assign sram_ub_n = 1'b0;
    assign sram_lb_n = 1'b0;
    assign sram_dq   = (active && op_wr) ? ((state == HIGH) ? wdata[31:16] : wdata[15:0])
                                         : 16'hzzzz;

endmodule

// File: tb/tb_sram_controller.sv
// Testbench for sram_controller: small SRAM model on the bus, directed
// requests from a driver task, and a monitor that pops expected stall length
// and read data from a queue each time an access completes.

module tb_sram_controller;

    localparam int P = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rd_en = 1'b0;
    logic        wr_en = 1'b0;
    logic [31:0] address = '0;
    logic [31:0] write_data = '0;
    wire  [31:0] read_data;
    wire         ready;
    wire  [15:0] sram_dq;
    wire  [17:0] sram_addr;
    wire         sram_we_n, sram_oe_n, sram_ce_n, sram_ub_n, sram_lb_n;
    wire  [1:0]  dbg_state;

    int total = 0;
    int bad   = 0;

    // {stall_len[5:0], is_read, read_data[31:0]}
    logic [38:0] exp_q[$];

    sram_controller #(
        .ADDR_BASE(32'd1024), .SRAM_ADDR_W(18), .PHASE_CYCLES(P)
    ) dut (
        .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en),
        .address(address), .write_data(write_data),
        .read_data(read_data), .ready(ready), .sram_dq(sram_dq),
        .sram_addr(sram_addr), .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n),
        .sram_ce_n(sram_ce_n), .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n),
        .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    // SRAM model: 16 words, half-word h maps to {h[17], h[2:0]}, so words
    // 0..5 and the two top half-words 3FFFE/3FFFF are distinct.
    logic [15:0] mem [0:15] = '{14: 16'h1111, 15: 16'h2222, default: 16'h0000};

    function automatic int midx(input logic [17:0] a);
        return int'({a[17], a[2:0]});
    endfunction

    always @(posedge clk) begin
        if (!sram_ce_n && !sram_we_n) mem[midx(sram_addr)] <= sram_dq;
    end

    assign sram_dq = (!sram_ce_n && !sram_oe_n && sram_we_n) ? mem[midx(sram_addr)] : 16'hzzzz;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // monitor / scoreboard
    int stall = 0;
    always @(negedge clk) begin : monitor
        logic [38:0] e;
        if (rst) begin
            stall = 0;
        end else if (!ready) begin
            stall++;
        end else if (stall > 0) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_completion: got stall %0d expected none", stall);
            end else begin
                e = exp_q.pop_front();
                check32("stall_len", 32'(stall), {26'd0, e[38:33]});
                if (e[32]) check32("read_data", read_data, e[31:0]);
            end
            stall = 0;
        end
    end

    // driver: one request; checks strobes/address in the first LOW and HIGH cycles
    task automatic do_req(input logic wr, input logic rd, input logic [31:0] addr,
                          input logic [31:0] data, input logic [17:0] lo_hw,
                          input int exp_len, input logic [31:0] exp_rd);
        logic done;
        @(posedge clk); #1;
        wr_en = wr; rd_en = rd; address = addr; write_data = data;
        exp_q.push_back({6'(exp_len), rd & ~wr, exp_rd});
        @(negedge clk);
        check32("ready_drop", {31'd0, ready}, 32'd0);
        @(posedge clk); #1;
        // disturb inputs after IDLE to exercise latching
        wr_en = 1'b0; rd_en = 1'b0; address = addr ^ 32'h8; write_data = ~data;
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (ready) begin
                done = 1'b1;
            end else if (i == 0) begin
                check32("low_addr", {14'd0, sram_addr}, {14'd0, lo_hw});
                check32("low_ce_n", {31'd0, sram_ce_n}, 32'd0);
                check32("low_we_n", {31'd0, sram_we_n}, 32'(!wr));
                check32("low_oe_n", {31'd0, sram_oe_n}, 32'(wr));
            end else if (i == P) begin
                check32("high_addr", {14'd0, sram_addr}, {14'd0, lo_hw | 18'd1});
            end
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL ready_timeout: got no ready expected ready within 20 cycles");
        end
    endtask

    initial begin
        // asynchronous reset with no clock edge
        #3 rst = 1'b1;
        #1;
        check32("rst_read_data", read_data, 32'd0);
        check32("rst_we_n", {31'd0, sram_we_n}, 32'd1);
        check32("rst_oe_n", {31'd0, sram_oe_n}, 32'd1);
        check32("rst_ce_n", {31'd0, sram_ce_n}, 32'd1);
        check32("rst_ready", {31'd0, ready}, 32'd1);
        check32("rst_state", {30'd0, dbg_state}, 32'd0);
        check32("rst_sram_addr", {14'd0, sram_addr}, 32'd0);
        @(negedge clk); @(negedge clk); #1 rst = 1'b0;

        // write then read
        do_req(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, 18'd0, 2*P+1, 32'd0);
        check32("mem_hw0", {16'd0, mem[0]}, 32'h0000BEEF);
        check32("mem_hw1", {16'd0, mem[1]}, 32'h0000DEAD);
        do_req(1'b0, 1'b1, 32'd1024, 32'd0, 18'd0, 2*P+1, 32'hDEADBEEF);

        // adjacency and alignment
        do_req(1'b1, 1'b0, 32'd1028, 32'h12345678, 18'd2, 2*P+1, 32'd0);
        do_req(1'b0, 1'b1, 32'd1024, 32'd0, 18'd0, 2*P+1, 32'hDEADBEEF);
        do_req(1'b0, 1'b1, 32'd1031, 32'd0, 18'd2, 2*P+1, 32'h12345678);

        // priority and latching: both enables, inputs changed during LOW
        do_req(1'b1, 1'b1, 32'd1032, 32'hA5A55A5A, 18'd4, 2*P+1, 32'd0);
        check32("prio_hw4", {16'd0, mem[4]}, 32'h00005A5A);
        check32("prio_hw5", {16'd0, mem[5]}, 32'h0000A5A5);
        check32("prio_hw0", {16'd0, mem[0]}, 32'h0000BEEF);
        check32("prio_hw1", {16'd0, mem[1]}, 32'h0000DEAD);

        // reset during HIGH of a read
        @(posedge clk); #1 rd_en = 1'b1; address = 32'd1028;
        @(posedge clk); #1 rd_en = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check32("midrst_ce_n", {31'd0, sram_ce_n}, 32'd1);
        check32("midrst_oe_n", {31'd0, sram_oe_n}, 32'd1);
        check32("midrst_we_n", {31'd0, sram_we_n}, 32'd1);
        check32("midrst_read_data", read_data, 32'd0);
        check32("midrst_ready", {31'd0, ready}, 32'd1);
        check32("midrst_state", {30'd0, dbg_state}, 32'd0);
        @(negedge clk); #1 rst = 1'b0;
        do_req(1'b0, 1'b1, 32'd1028, 32'd0, 18'd2, 2*P+1, 32'h12345678);

        // below ADDR_BASE
`ifdef SRAM_RANGE_CHECK_EN
        do_req(1'b0, 1'b1, 32'd1020, 32'd0, 18'd0, 1, 32'd0);
`else
        do_req(1'b0, 1'b1, 32'd1020, 32'd0, 18'h3FFFE, 2*P+1, 32'h22221111);
`endif

        repeat (3) @(negedge clk);
        check32("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish before 100000");
        $fatal(1, "watchdog");
    end

endmodule
